dm_cache_ctrl: RTL and testbench

- Parametrised direct-mapped, write-back, write-allocate data cache controller for the 8-bit processor family.
- Sits between the core's data-memory port and a slower main memory.
- Replaces the fixed swap-based cache/main-memory pair with a req/ack handshake on both sides.
- Line = one data word. Width and depth are generic.

---
 rtl/dm_cache_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl
//   Direct-mapped, write-back, write-allocate data cache controller. One data
//   word per line. The core side and the main-memory side both use a req/ack
//   style handshake; every output towards either side is registered.
//
// Optional feature:
//   DM_CACHE_STATS_EN  when defined, hit_cnt/miss_cnt count accepted hits and
//                      misses (saturating at 16'hFFFF). When undefined both
//                      outputs are tied to zero and no counter logic exists.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   cpu_req    core request, held with stable operands until cpu_ready
//   cpu_we     1 = store, 0 = load
//   cpu_addr   word address (index = low INDEX_W bits, tag = remaining bits)
//   cpu_wdata  store data
//   cpu_ready  one-cycle completion pulse
//   cpu_rdata  load data, valid while cpu_ready is high
//   mem_req    main-memory request
//   mem_we     1 = writeback, 0 = refill read
//   mem_addr   main-memory word address
//   mem_wdata  writeback data
//   mem_ack    main-memory completion, mem_rdata valid in the same cycle
//   mem_rdata  refill data
//   hit_cnt    accepted-hit counter
//   miss_cnt   accepted-miss counter

module dm_cache_ctrl #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int INDEX_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, WB, FILL, RESP} state_t;

  state_t state, state_next;

  // Line storage. Only valid/dirty are reset; tag/data are meaningless
  // until the corresponding valid bit is set.
  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES];

  // Request operands captured at acceptance so the core may change them
  // while a miss is being serviced.
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic [INDEX_W-1:0] cpu_idx, req_idx;
  logic [TAG_W-1:0]   cpu_tag, req_tag;
  logic               hit;

  logic              ready_next;
  logic [DATA_W-1:0] rdata_next;
  logic              mem_req_next;
  logic              mem_we_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_next;
  logic              capture;
  logic              line_we;
  logic [INDEX_W-1:0] line_idx;
  logic [TAG_W-1:0]  line_tag;
  logic [DATA_W-1:0] line_data;
  logic              line_dirty;
  logic              dirty_clr;

  assign cpu_idx = cpu_addr[INDEX_W-1:0];
  assign cpu_tag = cpu_addr[ADDR_W-1:INDEX_W];
  assign req_idx = req_addr[INDEX_W-1:0];
  assign req_tag = req_addr[ADDR_W-1:INDEX_W];
  assign hit     = valid[cpu_idx] && (tag_arr[cpu_idx] == cpu_tag);

  // Next-state and next-output logic. Registered outputs hold their value
  // unless a state explicitly changes them; cpu_ready defaults low so it
  // can only ever be a single-cycle pulse.
  always_comb begin
    state_next     = state;
    ready_next     = 1'b0;
    rdata_next     = cpu_rdata;
    mem_req_next   = mem_req;
    mem_we_next    = mem_we;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    capture        = 1'b0;
    line_we        = 1'b0;
    line_idx       = req_idx;
    line_tag       = req_tag;
    line_data      = req_wdata;
    line_dirty     = 1'b0;
    dirty_clr      = 1'b0;

    case (state)
      IDLE: begin
        line_idx  = cpu_idx;
        line_tag  = cpu_tag;
        line_data = cpu_wdata;
        if (cpu_req) begin
          capture = 1'b1;
          if (hit) begin
            ready_next = 1'b1;
            state_next = RESP;
            if (cpu_we) begin
              line_we    = 1'b1;
              line_dirty = 1'b1;
            end else begin
              rdata_next = data_arr[cpu_idx];
            end
          end else if (valid[cpu_idx] && dirty[cpu_idx]) begin
            state_next     = WB;
            mem_req_next   = 1'b1;
            mem_we_next    = 1'b1;
            mem_addr_next  = {tag_arr[cpu_idx], cpu_idx};
            mem_wdata_next = data_arr[cpu_idx];
          end else if (!cpu_we) begin
            state_next    = FILL;
            mem_req_next  = 1'b1;
            mem_we_next   = 1'b0;
            mem_addr_next = cpu_addr;
          end else begin
            // Clean store miss: a one-word line is fully overwritten, so
            // there is nothing to fetch.
            line_we    = 1'b1;
            line_dirty = 1'b1;
            ready_next = 1'b1;
            state_next = RESP;
          end
        end
      end

      WB: begin
        if (mem_ack) begin
          mem_req_next = 1'b0;
          if (req_we) begin
            line_we    = 1'b1;
            line_dirty = 1'b1;
            ready_next = 1'b1;
            state_next = RESP;
          end else begin
            dirty_clr  = 1'b1;
            state_next = FILL;
          end
        end
      end

      FILL: begin
        // Arriving from WB, mem_req is low: raise it one edge later so the
        // memory always sees a gap between two transactions. Any mem_ack
        // seen while mem_req is low is ignored.
        if (!mem_req) begin
          mem_req_next  = 1'b1;
          mem_we_next   = 1'b0;
          mem_addr_next = req_addr;
        end else if (mem_ack) begin
          line_we      = 1'b1;
          line_data    = mem_rdata;
          line_dirty   = 1'b0;
          rdata_next   = mem_rdata;
          ready_next   = 1'b1;
          mem_req_next = 1'b0;
          state_next   = RESP;
        end
      end

      RESP: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_next;
      cpu_ready <= ready_next;
      cpu_rdata <= rdata_next;
      mem_req   <= mem_req_next;
      mem_we    <= mem_we_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
    end
  end

  // Line status bits. A line write always sets valid and defines dirty;
  // the writeback-then-refill path clears dirty once the victim is saved.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (dirty_clr) begin
        dirty[req_idx] <= 1'b0;
      end
      if (line_we) begin
        valid[line_idx] <= 1'b1;
        dirty[line_idx] <= line_dirty;
      end
    end
  end

  // Tag/data arrays and captured operands carry no reset.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_arr[line_idx]  <= line_tag;
      data_arr[line_idx] <= line_data;
    end
    if (capture) begin
      req_we    <= cpu_we;
      req_addr  <= cpu_addr;
      req_wdata <= cpu_wdata;
    end
  end

`ifdef DM_CACHE_STATS_EN
  // Saturating hit/miss counters, stepped once per accepted request.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if ((state == IDLE) && cpu_req) begin
      if (hit) begin
        if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      end else begin
        if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl
//   Self-checking bench for dm_cache_ctrl (defaults DATA_W=8, ADDR_W=8,
//   INDEX_W=2). A directed vector table covers the main scenarios, a short
//   hand-written sequence covers reset during a refill, and a randomized run
//   is compared against a word-level model of the cache and main memory.

module tb_dm_cache_ctrl;

  localparam int LINES = 4;

`ifdef DM_CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        cpu_req;
  logic        cpu_we;
  logic [7:0]  cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ready;
  logic [7:0]  cpu_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  dm_cache_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ready (cpu_ready),
    .cpu_rdata (cpu_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main memory as seen by the DUT (written by its writebacks).
  logic [7:0] phys_mem [256];

  // Results of the last access.
  int         res_lat;
  int         res_ntx;
  logic [7:0] res_rdata;
  bit         res_timeout;
  logic       res_ready_after;
  logic       res_tx_we   [4];
  logic [7:0] res_tx_addr [4];
  logic [7:0] res_tx_data [4];

  // Reference model: cache lines, expected memory, counts.
  bit         m_valid [LINES];
  bit         m_dirty [LINES];
  int         m_tag   [LINES];
  logic [7:0] m_data  [LINES];
  logic [7:0] m_mem   [256];
  int         m_hits;
  int         m_misses;

  typedef struct {
    bit         do_reset;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         wait_cyc;
    bit         chk_rdata;
    logic [7:0] exp_rdata;
    int         exp_lat;
    int         exp_ntx;
    bit         tx0_we;
    logic [7:0] tx0_addr;
    logic [7:0] tx0_data;
    logic [7:0] tx1_addr;
    int         exp_hits;
    int         exp_misses;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic initMemories();
    for (int i = 0; i < 256; i++) begin
      phys_mem[i] = 8'(i) ^ 8'h5A;
    end
    phys_mem[8'h05] = 8'hA7;
    phys_mem[8'h09] = 8'h5B;
    for (int i = 0; i < 256; i++) begin
      m_mem[i] = phys_mem[i];
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < LINES; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  // Holds reset for two edges and checks every registered output is zero.
  task automatic doReset(input string tag);
    @(negedge clk);
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 8'h00;
    cpu_wdata = 8'h00;
    mem_ack   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput({tag, "_rst_cpu_ready"}, cpu_ready, 0);
    checkOutput({tag, "_rst_cpu_rdata"}, cpu_rdata, 0);
    checkOutput({tag, "_rst_mem_req"},   mem_req,   0);
    checkOutput({tag, "_rst_mem_we"},    mem_we,    0);
    checkOutput({tag, "_rst_mem_addr"},  mem_addr,  0);
    checkOutput({tag, "_rst_mem_wdata"}, mem_wdata, 0);
    checkOutput({tag, "_rst_hit_cnt"},   hit_cnt,   0);
    checkOutput({tag, "_rst_miss_cnt"},  miss_cnt,  0);
    rst = 1'b0;
    modelReset();
  endtask

  // Runs one core access starting at a negedge with the DUT idle. Acts as
  // main memory with wait_cyc wait cycles per transaction, scrambles the
  // core operands after acceptance, and injects stray acks while mem_req
  // is low. Ends one cycle after cpu_ready, with the DUT idle again.
  task automatic applyStimulus(input logic we, input logic [7:0] addr,
                               input logic [7:0] wdata, input int wait_cyc);
    int cyc;
    int waited;
    res_ntx     = 0;
    res_lat     = 0;
    res_rdata   = 8'h00;
    res_timeout = 1'b1;
    cpu_req     = 1'b1;
    cpu_we      = we;
    cpu_addr    = addr;
    cpu_wdata   = wdata;
    mem_ack     = 1'b0;
    waited      = 0;
    cyc         = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      if (cpu_ready) begin
        res_lat     = cyc;
        res_rdata   = cpu_rdata;
        res_timeout = 1'b0;
        break;
      end
      cpu_we    = 1'($urandom);
      cpu_addr  = 8'($urandom);
      cpu_wdata = 8'($urandom);
      if (mem_req) begin
        if (waited >= wait_cyc) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            phys_mem[mem_addr] = mem_wdata;
            mem_rdata = 8'($urandom);
          end else begin
            mem_rdata = phys_mem[mem_addr];
          end
          if (res_ntx < 4) begin
            res_tx_we[res_ntx]   = mem_we;
            res_tx_addr[res_ntx] = mem_addr;
            res_tx_data[res_ntx] = mem_wdata;
          end
          res_ntx++;
          waited = 0;
        end else begin
          waited++;
          mem_rdata = 8'($urandom);
        end
      end else begin
        waited    = 0;
        mem_ack   = ($urandom_range(0, 3) == 0);
        mem_rdata = 8'($urandom);
      end
    end
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    res_ready_after = cpu_ready;
  endtask

  task automatic checkResult(input string tag, input int exp_lat,
                             input bit chk_rdata, input logic [7:0] exp_rdata,
                             input int exp_ntx,
                             input bit tx0_we, input logic [7:0] tx0_addr,
                             input logic [7:0] tx0_data,
                             input logic [7:0] tx1_addr,
                             input int exp_hits, input int exp_misses);
    checkOutput({tag, "_timeout"}, res_timeout, 0);
    checkOutput({tag, "_latency"}, res_lat, exp_lat);
    checkOutput({tag, "_ready_pulse"}, res_ready_after, 0);
    if (chk_rdata) checkOutput({tag, "_rdata"}, res_rdata, exp_rdata);
    checkOutput({tag, "_mem_txns"}, res_ntx, exp_ntx);
    if (exp_ntx > 0 && res_ntx > 0) begin
      checkOutput({tag, "_tx0_we"}, res_tx_we[0], tx0_we);
      checkOutput({tag, "_tx0_addr"}, res_tx_addr[0], tx0_addr);
      if (tx0_we) checkOutput({tag, "_tx0_wdata"}, res_tx_data[0], tx0_data);
    end
    if (exp_ntx > 1 && res_ntx > 1) begin
      checkOutput({tag, "_tx1_we"}, res_tx_we[1], 0);
      checkOutput({tag, "_tx1_addr"}, res_tx_addr[1], tx1_addr);
    end
    checkOutput({tag, "_hit_cnt"}, hit_cnt, STATS ? exp_hits : 0);
    checkOutput({tag, "_miss_cnt"}, miss_cnt, STATS ? exp_misses : 0);
  endtask

  // Word-level model: predicts one access and updates its own state.
  task automatic modelAccess(input string tag, input logic we,
                             input logic [7:0] addr, input logic [7:0] wdata,
                             input int w);
    int idx;
    int tg;
    bit wb;
    int e_lat;
    int e_ntx;
    logic [7:0] e_rdata;
    logic [7:0] wb_addr;
    logic [7:0] wb_data;
    idx     = int'(addr) % LINES;
    tg      = int'(addr) / LINES;
    e_rdata = 8'h00;
    wb_addr = 8'h00;
    wb_data = 8'h00;
    wb      = 1'b0;
    e_ntx   = 0;
    if (m_valid[idx] && m_tag[idx] == tg) begin
      m_hits = (m_hits < 65535) ? m_hits + 1 : m_hits;
      e_lat  = 1;
      if (we) begin
        m_data[idx]  = wdata;
        m_dirty[idx] = 1'b1;
      end else begin
        e_rdata = m_data[idx];
      end
    end else begin
      m_misses = (m_misses < 65535) ? m_misses + 1 : m_misses;
      wb = m_valid[idx] && m_dirty[idx];
      if (wb) begin
        wb_addr = 8'(m_tag[idx] * LINES + idx);
        wb_data = m_data[idx];
        m_mem[wb_addr] = wb_data;
        e_ntx = 1;
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      if (we) begin
        m_data[idx]  = wdata;
        m_dirty[idx] = 1'b1;
        e_lat = wb ? 2 + w : 1;
      end else begin
        m_data[idx]  = m_mem[addr];
        m_dirty[idx] = 1'b0;
        e_rdata      = m_data[idx];
        e_ntx        = e_ntx + 1;
        e_lat        = wb ? 4 + 2 * w : 2 + w;
      end
    end
    checkResult(tag, e_lat, !we, e_rdata, e_ntx,
                wb ? 1'b1 : 1'b0, wb ? wb_addr : addr, wb_data, addr,
                m_hits, m_misses);
  endtask

  initial begin
    rst       = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = 8'h00;
    cpu_wdata = 8'h00;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;

    //          rst we addr   wdata  w chk rdata  lat ntx tx0we tx0a   tx0d   tx1a   h  m
    vecs[0] = '{1, 0, 8'h05, 8'h00, 3, 1, 8'hA7, 5, 1, 0, 8'h05, 8'h00, 8'h00, 0, 1};
    vecs[1] = '{0, 0, 8'h05, 8'h00, 0, 1, 8'hA7, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1};
    vecs[2] = '{0, 1, 8'h05, 8'h3C, 0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h00, 2, 1};
    vecs[3] = '{0, 0, 8'h09, 8'h00, 1, 1, 8'h5B, 6, 2, 1, 8'h05, 8'h3C, 8'h09, 2, 2};
    vecs[4] = '{1, 1, 8'h0A, 8'h11, 0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0, 1};
    vecs[5] = '{0, 0, 8'h0A, 8'h00, 0, 1, 8'h11, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 1};
    vecs[6] = '{0, 1, 8'h0E, 8'h22, 2, 0, 8'h00, 4, 1, 1, 8'h0A, 8'h11, 8'h00, 1, 2};
    vecs[7] = '{0, 0, 8'h0E, 8'h00, 0, 1, 8'h22, 1, 0, 0, 8'h00, 8'h00, 8'h00, 2, 2};
    vecs[8] = '{0, 0, 8'h0E, 8'h00, 1, 1, 8'h22, 1, 0, 0, 8'h00, 8'h00, 8'h00, 3, 2};

    initMemories();
    repeat (2) @(negedge clk);

    $display("[TB] directed vectors");
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_reset) doReset($sformatf("v%0d", i));
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wait_cyc);
      checkResult($sformatf("v%0d", i), vecs[i].exp_lat, vecs[i].chk_rdata,
                  vecs[i].exp_rdata, vecs[i].exp_ntx, vecs[i].tx0_we,
                  vecs[i].tx0_addr, vecs[i].tx0_data, vecs[i].tx1_addr,
                  vecs[i].exp_hits, vecs[i].exp_misses);
    end

    $display("[TB] reset during refill");
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 8'h01;
    cpu_wdata = 8'h00;
    mem_ack   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midfill_mem_req_held", mem_req, 1);
    checkOutput("midfill_mem_we", mem_we, 0);
    checkOutput("midfill_mem_addr", mem_addr, 8'h01);
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    checkOutput("midfill_rst_mem_req", mem_req, 0);
    checkOutput("midfill_rst_cpu_ready", cpu_ready, 0);
    rst = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("midfill_after_cpu_ready", cpu_ready, 0);
    checkOutput("midfill_after_mem_req", mem_req, 0);
    // Line 1 was invalidated, and memory now holds the earlier writeback.
    applyStimulus(1'b0, 8'h05, 8'h00, 0);
    checkResult("midfill_reload", 2, 1'b1, 8'h3C, 1, 1'b0, 8'h05, 8'h00,
                8'h00, 0, 1);

    $display("[TB] randomized accesses");
    doReset("rand");
    initMemories();
    for (int n = 0; n < 300; n++) begin
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      int         w;
      we    = 1'($urandom);
      addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      wdata = 8'($urandom);
      w     = $urandom_range(0, 3);
      applyStimulus(we, addr, wdata, w);
      modelAccess($sformatf("r%0d", n), we, addr, wdata, w);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
